// File: rtl/microsequencer.sv
// microsequencer
// Writable-control-store microsequencer for the multi-cycle CPU controller.
// It holds a microcode RAM, a micro-PC (upc) and a registered copy of the
// current microword (uir), and it emits one control word per cycle. It supports
// FETCH, NEXT, DISPATCH, JUMP, BRANCH, CALL, RETURN and HALT sequencing, and it
// stalls on a ready handshake when the microword has its wait bit set.
//
// Microword layout, MSB to LSB:
//   ctrl[CTRL_WIDTH], wait, mode[3], cond_sel, cond_pol, disp_sel, target
//
// Ports:
//   clock          clock
//   reset          synchronous, active-high reset (does not clear the store)
//   i_disp_addr    dispatch targets; table k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   i_cond         branch condition inputs
//   i_ready        completion handshake for wait microwords
//   i_uw_en        control-store write enable
//   i_uw_addr      control-store write address
//   i_uw_data      control-store write data
//   o_control_bus  control field of the current microword
//   o_req          current microword is waiting for ready
//   o_upc          current micro-PC
//   o_halted       sequencer stopped
//   o_error        sticky stack overflow/underflow
module microsequencer #(
  parameter int CTRL_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int STACK_DEPTH   = 4,
  parameter int COND_SEL_BITS = 2,
  parameter int DISP_SEL_BITS = 2,
  parameter logic [ADDR_WIDTH-1:0] FETCH_ADDR = '0,
  localparam int NUM_COND = 2 ** COND_SEL_BITS,
  localparam int NUM_DISP = 2 ** DISP_SEL_BITS,
  localparam int UW = CTRL_WIDTH + 1 + 3 + COND_SEL_BITS + 1 + DISP_SEL_BITS + ADDR_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_DISP*ADDR_WIDTH-1:0] i_disp_addr,
  input  logic [NUM_COND-1:0]          i_cond,
  input  logic                         i_ready,
  input  logic                         i_uw_en,
  input  logic [ADDR_WIDTH-1:0]        i_uw_addr,
  input  logic [UW-1:0]                i_uw_data,
  output logic [CTRL_WIDTH-1:0]        o_control_bus,
  output logic                         o_req,
  output logic [ADDR_WIDTH-1:0]        o_upc,
  output logic                         o_halted,
  output logic                         o_error
);

  // Field positions inside a microword, counted from the LSB.
  localparam int DSEL_LSB  = ADDR_WIDTH;
  localparam int POL_BIT   = DSEL_LSB + DISP_SEL_BITS;
  localparam int CSEL_LSB  = POL_BIT + 1;
  localparam int MODE_LSB  = CSEL_LSB + COND_SEL_BITS;
  localparam int WAIT_BIT  = MODE_LSB + 3;
  localparam int CTRL_LSB  = WAIT_BIT + 1;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;

  // Stack pointer spans 0..STACK_DEPTH; entry index only needs 0..STACK_DEPTH-1.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0]       SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]       SP_ONE  = SP_W'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    M_FETCH    = 3'd0,
    M_NEXT     = 3'd1,
    M_DISPATCH = 3'd2,
    M_JUMP     = 3'd3,
    M_BRANCH   = 3'd4,
    M_CALL     = 3'd5,
    M_RETURN   = 3'd6,
    M_HALT     = 3'd7
  } mode_e;

  logic [UW-1:0]         r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_stack [0:(2**IDX_W)-1];
  logic [ADDR_WIDTH-1:0] r_upc;
  logic [UW-1:0]         r_uir;
  logic [SP_W-1:0]       r_sp;
  logic                  r_halted;
  logic                  r_error;

  mode_e                    w_mode;
  logic                     w_wait;
  logic [COND_SEL_BITS-1:0] w_cond_sel;
  logic                     w_cond_pol;
  logic [DISP_SEL_BITS-1:0] w_disp_sel;
  logic [ADDR_WIDTH-1:0]    w_target;
  logic [ADDR_WIDTH-1:0]    w_upc_inc;
  logic [SP_W-1:0]          w_sp_dec;
  logic [IDX_W-1:0]         w_top_idx;
  logic [IDX_W-1:0]         w_push_idx;
  logic                     w_advance;
  logic [ADDR_WIDTH-1:0]    w_next;
  logic                     w_load;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_set_halt;
  logic                     w_set_err;
  logic [UW-1:0]            w_next_word;

  assign w_mode     = mode_e'(r_uir[MODE_LSB +: 3]);
  assign w_wait     = r_uir[WAIT_BIT];
  assign w_cond_sel = r_uir[CSEL_LSB +: COND_SEL_BITS];
  assign w_cond_pol = r_uir[POL_BIT];
  assign w_disp_sel = r_uir[DSEL_LSB +: DISP_SEL_BITS];
  assign w_target   = r_uir[ADDR_WIDTH-1:0];
  assign w_upc_inc  = r_upc + A_ONE;
  assign w_sp_dec   = r_sp - SP_ONE;
  assign w_top_idx  = w_sp_dec[IDX_W-1:0];
  assign w_push_idx = r_sp[IDX_W-1:0];

  // A wait microword only moves on when ready is seen in the same cycle.
  assign w_advance = ~r_halted & (~w_wait | i_ready);

  // Next-address selection and stack/halt side effects of the current microword.
  always_comb begin
    w_next     = w_upc_inc;
    w_load     = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_set_halt = 1'b0;
    w_set_err  = 1'b0;
    case (w_mode)
      M_FETCH: begin
        w_next = FETCH_ADDR;
        w_load = 1'b1;
      end
      M_NEXT: begin
        w_next = w_upc_inc;
        w_load = 1'b1;
      end
      M_DISPATCH: begin
        w_next = i_disp_addr[w_disp_sel*ADDR_WIDTH +: ADDR_WIDTH];
        w_load = 1'b1;
      end
      M_JUMP: begin
        w_next = w_target;
        w_load = 1'b1;
      end
      M_BRANCH: begin
        if (i_cond[w_cond_sel] ^ w_cond_pol) begin
          w_next = w_target;
        end else begin
          w_next = w_upc_inc;
        end
        w_load = 1'b1;
      end
      M_CALL: begin
        if (r_sp < SP_FULL) begin
          w_next = w_target;
          w_load = 1'b1;
          w_push = 1'b1;
        end else begin
          // Overflow: freeze on this microword with the error flagged.
          w_set_err  = 1'b1;
          w_set_halt = 1'b1;
        end
      end
      M_RETURN: begin
        if (r_sp != '0) begin
          w_next = r_stack[w_top_idx];
          w_load = 1'b1;
          w_pop  = 1'b1;
        end else begin
          w_set_err  = 1'b1;
          w_set_halt = 1'b1;
        end
      end
      M_HALT: begin
        w_set_halt = 1'b1;
      end
      default: begin
        w_set_halt = 1'b1;
      end
    endcase
  end

  // Write-first: a word written on the advancing edge reaches uir directly.
  always_comb begin
    w_next_word = r_mem[w_next];
    if (i_uw_en && (i_uw_addr == w_next)) begin
      w_next_word = i_uw_data;
    end else begin
      w_next_word = r_mem[w_next];
    end
  end

  // Control store write port; unaffected by reset or halt.
  always_ff @(posedge clock) begin
    if (i_uw_en) begin
      r_mem[i_uw_addr] <= i_uw_data;
    end
  end

  // Return-address stack storage; only the pointer is reset.
  always_ff @(posedge clock) begin
    if (!reset && w_advance && w_push) begin
      r_stack[w_push_idx] <= w_upc_inc;
    end
  end

  // Sequencer state: micro-PC, instruction register, stack pointer, flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_upc    <= '0;
      r_uir    <= '0;
      r_sp     <= '0;
      r_halted <= 1'b0;
      r_error  <= 1'b0;
    end else if (w_advance) begin
      if (w_load) begin
        r_upc <= w_next;
        r_uir <= w_next_word;
      end
      if (w_push) begin
        r_sp <= r_sp + SP_ONE;
      end else if (w_pop) begin
        r_sp <= w_sp_dec;
      end
      if (w_set_halt) begin
        r_halted <= 1'b1;
      end
      if (w_set_err) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_control_bus = r_uir[CTRL_LSB +: CTRL_WIDTH];
  assign o_req         = w_wait & ~r_halted;
  assign o_upc         = r_upc;
  assign o_halted      = r_halted;
  assign o_error       = r_error;

endmodule

// File: tb/tb_microsequencer.sv
// Directed self-checking bench for microsequencer (default parameters).
module tb_microsequencer;

  logic        clock;
  logic        reset;
  logic [23:0] disp_addr;
  logic [3:0]  cond;
  logic        ready;
  logic        uw_en;
  logic [5:0]  uw_addr;
  logic [30:0] uw_data;
  logic [15:0] control_bus;
  logic        req;
  logic [5:0]  upc;
  logic        halted;
  logic        error;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] FETCH = 3'd0, NEXT = 3'd1, DISP = 3'd2, JUMP = 3'd3,
                         BRANCH = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

  microsequencer dut (
    .clock         (clock),
    .reset         (reset),
    .i_disp_addr   (disp_addr),
    .i_cond        (cond),
    .i_ready       (ready),
    .i_uw_en       (uw_en),
    .i_uw_addr     (uw_addr),
    .i_uw_data     (uw_data),
    .o_control_bus (control_bus),
    .o_req         (req),
    .o_upc         (upc),
    .o_halted      (halted),
    .o_error       (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [30:0] mw(input logic [15:0] c, input logic w, input logic [2:0] m,
                                     input logic [1:0] cs, input logic p, input logic [1:0] ds,
                                     input logic [5:0] t);
    return {c, w, m, cs, p, ds, t};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [30:0] d);
    uw_en = 1'b1; uw_addr = a; uw_data = d;
    tick();
    uw_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; disp_addr = {6'd3, 6'd37, 6'd2, 6'd1}; cond = 4'b0000;
    ready = 1'b0; uw_en = 1'b0; uw_addr = 6'd0; uw_data = 31'd0;
    tick();

    // Sequence A: NEXT / JUMP loop, store loaded while reset is held.
    wr(6'd0, mw(16'h0001, 1'b0, NEXT, 2'd0, 1'b0, 2'd0, 6'd0));
    wr(6'd1, mw(16'h0002, 1'b0, JUMP, 2'd0, 1'b0, 2'd0, 6'd0));
    check("rst_cb", control_bus, 32'h0);
    check("rst_req", req, 32'h0);
    check("rst_upc", upc, 32'h0);
    check("rst_halt", halted, 32'h0);
    check("rst_err", error, 32'h0);
    reset = 1'b0;
    tick(); check("a_upc0", upc, 32'd0); check("a_cb0", control_bus, 32'h1);
    tick(); check("a_upc1", upc, 32'd1); check("a_cb1", control_bus, 32'h2);
    tick(); check("a_upc2", upc, 32'd0); check("a_cb2", control_bus, 32'h1);
    tick(); check("a_upc3", upc, 32'd1); check("a_cb3", control_bus, 32'h2);

    // Sequence B: wait microword stalls until ready.
    reset = 1'b1; tick();
    wr(6'd1, mw(16'h0003, 1'b1, NEXT, 2'd0, 1'b0, 2'd0, 6'd0));
    wr(6'd2, mw(16'h0004, 1'b0, HALT, 2'd0, 1'b0, 2'd0, 6'd0));
    reset = 1'b0;
    tick(); check("b_upc0", upc, 32'd0); check("b_req0", req, 32'h0);
    tick(); check("b_stall1_upc", upc, 32'd1); check("b_stall1_req", req, 32'h1);
    check("b_stall1_cb", control_bus, 32'h3);
    tick(); check("b_stall2_upc", upc, 32'd1); check("b_stall2_req", req, 32'h1);
    tick(); check("b_stall3_upc", upc, 32'd1); check("b_stall3_req", req, 32'h1);
    ready = 1'b1;
    check("b_stall4_req", req, 32'h1);
    tick(); ready = 1'b0;
    check("b_go_upc", upc, 32'd2); check("b_go_req", req, 32'h0); check("b_go_cb", control_bus, 32'h4);
    tick(); check("b_halt", halted, 32'h1); check("b_halt_upc", upc, 32'd2);
    check("b_halt_err", error, 32'h0);

    // Sequence C: dispatch table 2, branch on cond[3] with inverted polarity.
    reset = 1'b1; tick();
    wr(6'd0, mw(16'h0001, 1'b0, DISP, 2'd0, 1'b0, 2'd2, 6'd0));
    wr(6'd37, mw(16'h0025, 1'b0, BRANCH, 2'd3, 1'b1, 2'd0, 6'd50));
    wr(6'd38, mw(16'h0026, 1'b0, BRANCH, 2'd3, 1'b1, 2'd0, 6'd50));
    wr(6'd50, mw(16'h0032, 1'b0, HALT, 2'd0, 1'b0, 2'd0, 6'd0));
    reset = 1'b0; cond = 4'b1000;
    tick(); check("c_upc0", upc, 32'd0);
    tick(); check("c_disp_upc", upc, 32'd37); check("c_disp_cb", control_bus, 32'h25);
    tick(); check("c_br_nt", upc, 32'd38);
    cond = 4'b0111;
    tick(); check("c_br_t", upc, 32'd50); check("c_br_t_cb", control_bus, 32'h32);

    // Sequence D: call/return, then stack overflow on the fifth nested call.
    reset = 1'b1; tick();
    wr(6'd0, mw(16'h0001, 1'b0, JUMP, 2'd0, 1'b0, 2'd0, 6'd5));
    wr(6'd5, mw(16'h0005, 1'b0, CALL, 2'd0, 1'b0, 2'd0, 6'd20));
    wr(6'd20, mw(16'h0014, 1'b0, RET, 2'd0, 1'b0, 2'd0, 6'd0));
    wr(6'd6, mw(16'h0006, 1'b0, JUMP, 2'd0, 1'b0, 2'd0, 6'd30));
    wr(6'd30, mw(16'h001e, 1'b0, CALL, 2'd0, 1'b0, 2'd0, 6'd31));
    wr(6'd31, mw(16'h001f, 1'b0, CALL, 2'd0, 1'b0, 2'd0, 6'd32));
    wr(6'd32, mw(16'h0020, 1'b0, CALL, 2'd0, 1'b0, 2'd0, 6'd33));
    wr(6'd33, mw(16'h0021, 1'b0, CALL, 2'd0, 1'b0, 2'd0, 6'd34));
    wr(6'd34, mw(16'h0022, 1'b1, CALL, 2'd0, 1'b0, 2'd0, 6'd35));
    reset = 1'b0; ready = 1'b1;
    tick(); check("d_upc0", upc, 32'd0);
    tick(); check("d_call_from", upc, 32'd5);
    tick(); check("d_call_to", upc, 32'd20); check("d_call_cb", control_bus, 32'h14);
    tick(); check("d_ret", upc, 32'd6); check("d_ret_cb", control_bus, 32'h6);
    tick(); check("d_n30", upc, 32'd30);
    tick(); check("d_n31", upc, 32'd31);
    tick(); check("d_n32", upc, 32'd32);
    tick(); check("d_n33", upc, 32'd33);
    tick(); check("d_n34", upc, 32'd34); check("d_n34_req", req, 32'h1);
    tick(); check("d_ovf_err", error, 32'h1); check("d_ovf_halt", halted, 32'h1);
    check("d_ovf_req", req, 32'h0); check("d_ovf_upc", upc, 32'd34);
    tick(); tick();
    check("d_frozen_upc", upc, 32'd34); check("d_frozen_cb", control_bus, 32'h22);
    ready = 1'b0;

    // Sequence E: upc wrap at 63, RETURN with empty stack, recovery by reset.
    reset = 1'b1; tick();
    wr(6'd0, mw(16'h0001, 1'b0, JUMP, 2'd0, 1'b0, 2'd0, 6'd63));
    wr(6'd63, mw(16'h003f, 1'b0, NEXT, 2'd0, 1'b0, 2'd0, 6'd0));
    reset = 1'b0;
    tick(); tick(); check("e_at63", upc, 32'd63);
    tick(); check("e_wrap", upc, 32'd0); check("e_wrap_cb", control_bus, 32'h1);
    reset = 1'b1; tick();
    wr(6'd0, mw(16'h0007, 1'b0, RET, 2'd0, 1'b0, 2'd0, 6'd0));
    reset = 1'b0;
    tick(); check("e_ret_cb", control_bus, 32'h7);
    tick(); check("e_unf_err", error, 32'h1); check("e_unf_halt", halted, 32'h1);
    check("e_unf_upc", upc, 32'd0);
    reset = 1'b1; tick();
    check("e_rst_err", error, 32'h0); check("e_rst_halt", halted, 32'h0);
    check("e_rst_upc", upc, 32'd0); check("e_rst_cb", control_bus, 32'h0);

    // Sequence F: write-first on the advancing edge, no uir update while halted.
    wr(6'd0, mw(16'h0001, 1'b0, JUMP, 2'd0, 1'b0, 2'd0, 6'd9));
    wr(6'd9, mw(16'h0009, 1'b0, HALT, 2'd0, 1'b0, 2'd0, 6'd0));
    reset = 1'b0;
    tick(); check("f_upc0", upc, 32'd0);
    wr(6'd9, mw(16'hbeef, 1'b0, HALT, 2'd0, 1'b0, 2'd0, 6'd0));
    check("f_wf_upc", upc, 32'd9); check("f_wf_cb", control_bus, 32'hbeef);
    tick(); check("f_halt", halted, 32'h1);
    wr(6'd9, mw(16'h1234, 1'b0, HALT, 2'd0, 1'b0, 2'd0, 6'd0));
    check("f_hold_cb", control_bus, 32'hbeef);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Parametrised, writable-control-store microsequencer for the multi-cycle CPU controller.
- Holds a microcode RAM and a micro-PC, and emits one control word per cycle.
- Supports next, jump, multi-table dispatch, conditional branch, micro-call/return on a hardware stack, and halt.
- Stalls on a memory/unit ready handshake; external opcode decoders drive the dispatch targets.

Parameters:
- CTRL_WIDTH, 16, width of emitted control word
- ADDR_WIDTH, 6, micro-address width; store depth 2**ADDR_WIDTH
- STACK_DEPTH, 4, micro-return stack entries (>=1)
- COND_SEL_BITS, 2, condition select width; NUM_COND = 2**COND_SEL_BITS
- DISP_SEL_BITS, 2, dispatch-table select width; NUM_DISP = 2**DISP_SEL_BITS
- FETCH_ADDR, 0, micro-address targeted by FETCH mode
- UW (derived), CTRL_WIDTH+1+3+COND_SEL_BITS+1+DISP_SEL_BITS+ADDR_WIDTH; default 31

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- disp_addr  in  NUM_DISP*ADDR_WIDTH  dispatch targets; table k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- cond  in  NUM_COND  branch condition inputs
- ready  in  1  handshake completion from the serviced unit
- uw_en  in  1  control-store write enable
- uw_addr  in  ADDR_WIDTH  control-store write address
- uw_data  in  UW  control-store write data
- control_bus  out  CTRL_WIDTH  control field of current microword
- req  out  1  current microword is waiting for ready
- upc  out  ADDR_WIDTH  current micro-PC
- halted  out  1  sequencer stopped
- error  out  1  sticky stack overflow/underflow

Behaviour:
- Microword fields, MSB to LSB: ctrl[CTRL_WIDTH], wait, mode[3], cond_sel, cond_pol, disp_sel, target[ADDR_WIDTH].
- State: upc, uir (registered copy of mem[upc]), stack, stack pointer sp (0..STACK_DEPTH), halted, error.
- Reset:
  - Forces upc=0, uir=0, sp=0, halted=0, error=0.
  - Outputs are therefore control_bus=0, req=0, upc=0.
  - Control-store contents are not cleared.
- Output timing: control_bus=uir.ctrl and req=uir.wait & ~halted. Both are register-derived, with no combinational path from inputs.
- Advance condition: ~halted & (~uir.wait | ready).
  - On advance: upc<=N and uir<=mem[N], where N is the next address below.
  - Otherwise all state holds.
- Next-address modes (uir.mode):
  - 0 FETCH: N=FETCH_ADDR.
  - 1 NEXT: N=upc+1, wrapping modulo 2**ADDR_WIDTH.
  - 2 DISPATCH: N=disp_addr table[disp_sel], sampled in the advancing cycle.
  - 3 JUMP: N=target.
  - 4 BRANCH: N = (cond[cond_sel]^cond_pol) ? target : upc+1.
  - 5 CALL:
    - sp<STACK_DEPTH: push upc+1 (wrapped), sp++, N=target.
    - sp==STACK_DEPTH: error<=1, halted<=1, no push, upc unchanged.
  - 6 RETURN:
    - sp>0: N=stack top, sp--.
    - sp==0: error<=1, halted<=1.
  - 7 HALT: halted<=1; upc and uir hold.
- Halted: only reset clears halted or error.
- Control-store write:
  - mem[uw_addr]<=uw_data at the clock edge when uw_en=1.
  - Write-first: if the same edge advances to N==uw_addr, uir receives uw_data.
  - uir is never updated by a write unless advancing.
  - Writes are permitted during reset and while halted.
- ready is ignored when uir.wait=0; it is not latched across cycles.
- A wait microword whose mode is CALL/RETURN/BRANCH performs its action only on the advancing edge, exactly once.
- Reset during a stall: req=0 on the next cycle; any pending ready is discarded.
- Single-step semantics: one microword per advancing edge, so latency from decision to new control_bus is 1 clock.

Test Plan:
- Load mem[0]={ctrl=16'h0001,NEXT}, mem[1]={ctrl=16'h0002,JUMP,target=0}, then release reset -> control_bus sequence 0,1,2,1,2...; upc 0,0,1,0,1.
- Set mem[1] to wait=1, mode NEXT, with ready held low 3 cycles then high 1 -> req=1 for 4 cycles, upc=1 throughout; upc=2 the cycle after ready; req=0.
- DISPATCH with disp_sel=2 and disp_addr table2=6'd37 -> upc=37 next cycle. BRANCH cond_sel=3, pol=1, cond[3]=1 -> upc=upc+1; with cond[3]=0 -> upc=target.
- CALL from upc=5 to 20, RETURN at 20 -> upc 5,20,6. Five nested CALLs with STACK_DEPTH=4 -> fifth sets error=1, halted=1, req=0, upc frozen.
- Execute NEXT at upc=63 -> upc wraps to 0. RETURN with empty stack -> error=1, halted=1. Apply reset -> error=0, halted=0, upc=0.
- Write mem[9] on the same edge the sequencer jumps to 9 -> control_bus shows the new ctrl value immediately.
